bram_window_writer: RTL and testbench
=====================================

Name: bram_window_writer

Overview:
Producer side of the two-bank (ping-pong) BRAM window used by the feature-map datapath. Accepts a linear stream of words from the external-memory fetch path and writes them into a BRAM of 2*bound_range words, alternating between bank 0 (local 0..bound_range-1) and bank 1 (local bound_range..2*bound_range-1). Bank ownership is credit-based: the writer stalls when both banks are full and resumes when the window reader releases a bank. A global word at index g always lands at local address g mod (2*bound_range), which matches the reader's local mapping.

Parameters:
DATA_W, 32, width of stream and BRAM data
LOCAL_AW, 16, width of BRAM local address; 2*bound_range must be <= 2**LOCAL_AW

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a transfer, sampled only in IDLE
total_words  in  32  words in the transfer, sampled at start
bound_range  in  32  bank size in words, sampled at start
in_valid  in  1  stream word valid
in_data  in  DATA_W  stream word
in_ready  out  1  stream word accepted when in_valid && in_ready
release  in  1  one-cycle pulse from reader: oldest full bank consumed
bram_we  out  1  BRAM write enable
bram_addr  out  LOCAL_AW  BRAM local write address
bram_wdata  out  DATA_W  BRAM write data
wr_count  out  32  global words accepted in current transfer
status  out  2  00 idle, 01 filling, 10 stalled (no free bank), 11 done
err  out  1  sticky error flag, cleared by start

Behaviour:
- Reset: state IDLE, in_ready=0, bram_we=0, bram_addr=0, bram_wdata=0, wr_count=0, status=00, err=0, banks_free=2, bank=0, offset=0.
- FSM: IDLE -> FILL on start (latch total_words, bound_range; clear wr_count, err; banks_free=2, bank=0, offset=0).
  - start with total_words==0 -> DONE next cycle, no writes.
  - start with bound_range==0 -> DONE, err=1, no writes.
  - FILL -> WAIT when banks_free reaches 0 with words remaining.
  - WAIT -> FILL on release.
  - FILL -> DONE when the accepted beat makes wr_count==total_words.
  - DONE -> IDLE on start is not used; DONE -> FILL directly on start (same latching as IDLE). start in FILL/WAIT ignored.
- in_ready = (state==FILL) && (banks_free!=0); combinational from registered state only, no combinational dependence on in_valid.
- Write latency: a beat accepted in cycle N produces bram_we=1 in cycle N+1 with bram_addr = bank*bound_range + offset (truncated to LOCAL_AW) and bram_wdata = that beat. bram_we=0 in all other cycles. One write per accepted beat; back-to-back beats give back-to-back writes.
- Counters on accept: wr_count+1; offset+1. When offset==bound_range-1 on accept: offset<=0, bank toggles, the bank is complete (banks_free-1).
- Final beat (wr_count reaches total_words) also completes the current bank even if partial; offset/bank then hold.
- release: banks_free+1. release with simultaneous bank completion: banks_free unchanged. release when banks_free==2 (and no simultaneous completion): ignored, err=1.
- release accepted in any state including DONE (reader drains the last banks after done); ignored in IDLE.
- All arithmetic 32-bit unsigned; bank*bound_range computed as a mux (0 or bound_range), no multiplier.
- status: IDLE 00, FILL 01, WAIT 10, DONE 11.
- Reset mid-transfer: immediately returns to reset values; a pending write (the N+1 cycle) is dropped.

Test Plan:
- bound_range=4, total_words=6, in_valid held 1, release tied 0 -> writes at addr 0,1,2,3,4,5 one per cycle starting 1 cycle after first accept; status 11 after 6th accept; wr_count=6; err=0.
- bound_range=4, total_words=12, no release -> 8 writes (addr 0..7), in_ready drops after 8th accept, status=10; pulse release -> in_ready=1, next 4 writes at addr 0..3, then DONE.
- bound_range=3, total_words=9, release pulsed on the same cycle the 6th word is accepted -> no stall, status stays 01, 9 writes at addr 0,1,2,3,4,5,0,1,2.
- in_valid toggled 1/0 every cycle, bound_range=2, total_words=4 -> bram_we pulses only after accepted beats, addrs 0,1,2,3, data in order.
- release when banks_free==2 -> err=1 and stays 1 until next start; start with bound_range=0 -> status 11, err=1, no bram_we.
- reset_n asserted low mid-FILL after 3 accepts -> all outputs at reset values same cycle; new start restarts from addr 0 with wr_count=0.

Source files
------------

// File: rtl/bram_window_writer.sv
// Producer side of the ping-pong BRAM window: writes a linear word stream into two banks of
// bound_range words each, stalling on bank credits. The reader's release pulse is bank_release
// because "release" is a reserved word in SystemVerilog.
module bram_window_writer #(
  parameter int DATA_W   = 32,
  parameter int LOCAL_AW = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [31:0]         total_words,
  input  logic [31:0]         bound_range,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic                bank_release,
  output logic                bram_we,
  output logic [LOCAL_AW-1:0] bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  output logic [31:0]         wr_count,
  output logic [1:0]          status,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         total_q;
  logic [31:0]         bound_q;
  logic [31:0]         offset;
  logic                bank;
  logic [1:0]          banks_free;
  logic [1:0]          banks_free_nxt;

  logic                accept;
  logic [31:0]         count_inc;
  logic                last_beat;
  logic                bank_end;
  logic                bank_complete;
  logic                release_ok;
  logic                release_err;
  logic                start_ok;
  logic [LOCAL_AW-1:0] local_addr;

  assign in_ready      = (state == ST_FILL) && (banks_free != 2'd0);
  assign accept        = in_valid && in_ready;
  assign count_inc     = wr_count + 32'd1;
  assign last_beat     = accept && (count_inc == total_q);
  assign bank_end      = (offset == bound_q - 32'd1);
  assign bank_complete = accept && (last_beat || bank_end);
  assign release_ok    = bank_release && (state != ST_IDLE);
  assign start_ok      = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign status        = state;

  // Address is formed modulo 2**LOCAL_AW, so only the low bits of the base and offset matter.
  assign local_addr = (bank ? bound_q[LOCAL_AW-1:0] : {LOCAL_AW{1'b0}}) + offset[LOCAL_AW-1:0];

  // A release that coincides with a bank completion cancels out; a release with both banks
  // already free has nothing to return and is flagged.
  always_comb begin
    banks_free_nxt = banks_free;
    release_err    = 1'b0;
    if (release_ok && !bank_complete) begin
      if (banks_free == 2'd2) begin
        release_err = 1'b1;
      end else begin
        banks_free_nxt = banks_free + 2'd1;
      end
    end else if (!release_ok && bank_complete) begin
      banks_free_nxt = banks_free - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if ((bound_range == 32'd0) || (total_words == 32'd0)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (last_beat) begin
          state_nxt = ST_DONE;
        end else if (banks_free_nxt == 2'd0) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (banks_free_nxt != 2'd0) begin
          state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_q    <= 32'd0;
      bound_q    <= 32'd0;
      offset     <= 32'd0;
      bank       <= 1'b0;
      banks_free <= 2'd2;
      wr_count   <= 32'd0;
      err        <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= {LOCAL_AW{1'b0}};
      bram_wdata <= {DATA_W{1'b0}};
    end else begin
      bram_we <= accept;
      if (start_ok) begin
        total_q    <= total_words;
        bound_q    <= bound_range;
        offset     <= 32'd0;
        bank       <= 1'b0;
        banks_free <= 2'd2;
        wr_count   <= 32'd0;
        err        <= (bound_range == 32'd0);
      end else begin
        banks_free <= banks_free_nxt;
        if (release_err) begin
          err <= 1'b1;
        end
        if (accept) begin
          bram_addr  <= local_addr;
          bram_wdata <= in_data;
          wr_count   <= count_inc;
          // After the final beat the bank position freezes until the next start.
          if (!last_beat) begin
            if (bank_end) begin
              offset <= 32'd0;
              bank   <= ~bank;
            end else begin
              offset <= offset + 32'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_window_writer.sv
// Self-checking bench for bram_window_writer: a scoreboard of expected BRAM writes is filled on
// each handshake and drained as the DUT writes.
module tb_bram_window_writer;
  localparam int DATA_W   = 32;
  localparam int LOCAL_AW = 16;

  typedef struct {
    logic [LOCAL_AW-1:0] addr;
    logic [DATA_W-1:0]   data;
  } wr_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [31:0]         total_words = 32'd0;
  logic [31:0]         bound_range = 32'd0;
  logic                in_valid = 1'b0;
  logic [DATA_W-1:0]   in_data = '0;
  logic                in_ready;
  logic                bank_release = 1'b0;
  logic                bram_we;
  logic [LOCAL_AW-1:0] bram_addr;
  logic [DATA_W-1:0]   bram_wdata;
  logic [31:0]         wr_count;
  logic [1:0]          status;
  logic                err;

  int  errors = 0;
  int  checks = 0;
  int  g = 0;
  int  cur_bound = 1;
  int  writes_seen = 0;
  bit  prev_acc = 1'b0;
  bit  phase = 1'b1;
  bit  stall_seen = 1'b0;
  wr_t sb[$];

  bram_window_writer #(.DATA_W(DATA_W), .LOCAL_AW(LOCAL_AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .total_words(total_words),
    .bound_range(bound_range), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bank_release(bank_release), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .wr_count(wr_count), .status(status), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_for(int idx);
    return 32'hA500_0000 + 32'(idx) * 32'h0001_0003;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock: check outputs on the falling edge, record any handshake, then step past the rise.
  task automatic tick();
    wr_t exp_w;
    @(negedge clk);
    checkOutput("we_timing", 32'(bram_we), 32'(prev_acc));
    if (bram_we) begin
      writes_seen++;
      checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        checkOutput("bram_addr", 32'(bram_addr), 32'(exp_w.addr));
        checkOutput("bram_wdata", bram_wdata, exp_w.data);
      end
    end
    prev_acc = in_valid && in_ready;
    if (prev_acc) begin
      sb.push_back('{addr: LOCAL_AW'(g % (2 * cur_bound)), data: word_for(g)});
      g++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(bit toggle, int rel_at_g);
    in_valid     = toggle ? phase : 1'b1;
    phase        = ~phase;
    in_data      = word_for(g);
    bank_release = (g == rel_at_g);
    tick();
    if (status == 2'b10) stall_seen = 1'b1;
  endtask

  task automatic start_transfer(int total, int bound);
    total_words = 32'(total);
    bound_range = 32'(bound);
    in_valid    = 1'b0;
    g           = 0;
    cur_bound   = (bound == 0) ? 1 : bound;
    writes_seen = 0;
    stall_seen  = 1'b0;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic run_to_done(bit toggle, int rel_at_g, int budget);
    int n = 0;
    while (status != 2'b11 && n < budget) begin
      applyStimulus(toggle, rel_at_g);
      n++;
    end
    checkOutput("done_reached", 32'(status), 32'd3);
    in_valid     = 1'b0;
    bank_release = 1'b0;
    tick();
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_we", 32'(bram_we), 32'd0);
    checkOutput("rst_addr", 32'(bram_addr), 32'd0);
    checkOutput("rst_wdata", bram_wdata, 32'd0);
    checkOutput("rst_wr_count", wr_count, 32'd0);
    checkOutput("rst_status", 32'(status), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] bound 4, 6 words, continuous");
    start_transfer(6, 4);
    run_to_done(1'b0, -1, 30);
    checkOutput("t1_wr_count", wr_count, 32'd6);
    checkOutput("t1_writes", 32'(writes_seen), 32'd6);
    checkOutput("t1_err", 32'(err), 32'd0);

    $display("[TB] bound 4, 12 words, stall then release");
    start_transfer(12, 4);
    n = 0;
    while (status == 2'b01 && n < 30) begin
      applyStimulus(1'b0, -1);
      n++;
    end
    checkOutput("t2_stall_status", 32'(status), 32'd2);
    checkOutput("t2_stall_ready", 32'(in_ready), 32'd0);
    checkOutput("t2_stall_count", wr_count, 32'd8);
    tick();
    checkOutput("t2_still_stalled", 32'(status), 32'd2);
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    checkOutput("t2_resume_ready", 32'(in_ready), 32'd1);
    checkOutput("t2_resume_status", 32'(status), 32'd1);
    run_to_done(1'b0, -1, 30);
    checkOutput("t2_wr_count", wr_count, 32'd12);
    checkOutput("t2_writes", 32'(writes_seen), 32'd12);

    $display("[TB] bound 3, 9 words, release on 6th accept");
    start_transfer(9, 3);
    run_to_done(1'b0, 5, 30);
    checkOutput("t3_no_stall", 32'(stall_seen), 32'd0);
    checkOutput("t3_writes", 32'(writes_seen), 32'd9);

    $display("[TB] bound 2, 4 words, toggling valid");
    start_transfer(4, 2);
    phase = 1'b1;
    run_to_done(1'b1, -1, 40);
    checkOutput("t4_wr_count", wr_count, 32'd4);
    checkOutput("t4_writes", 32'(writes_seen), 32'd4);

    $display("[TB] error cases");
    start_transfer(2, 4);
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    tick();
    checkOutput("t5_err_set", 32'(err), 32'd1);
    checkOutput("t5_err_status", 32'(status), 32'd1);
    run_to_done(1'b0, -1, 20);
    checkOutput("t5_err_sticky", 32'(err), 32'd1);
    start_transfer(5, 0);
    checkOutput("t5_b0_status", 32'(status), 32'd3);
    checkOutput("t5_b0_err", 32'(err), 32'd1);
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    checkOutput("t5_b0_writes", 32'(writes_seen), 32'd0);
    start_transfer(0, 4);
    checkOutput("t5_t0_status", 32'(status), 32'd3);
    checkOutput("t5_t0_err", 32'(err), 32'd0);
    repeat (2) tick();
    checkOutput("t5_t0_writes", 32'(writes_seen), 32'd0);

    $display("[TB] reset mid-transfer");
    start_transfer(10, 4);
    n = 0;
    while (g < 3 && n < 20) begin
      applyStimulus(1'b0, -1);
      n++;
    end
    checkOutput("t6_pre_count", wr_count, 32'd3);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_we", 32'(bram_we), 32'd0);
    checkOutput("t6_rst_ready", 32'(in_ready), 32'd0);
    checkOutput("t6_rst_addr", 32'(bram_addr), 32'd0);
    checkOutput("t6_rst_wdata", bram_wdata, 32'd0);
    checkOutput("t6_rst_count", wr_count, 32'd0);
    checkOutput("t6_rst_status", 32'(status), 32'd0);
    sb.delete();
    prev_acc = 1'b0;
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    start_transfer(4, 4);
    checkOutput("t6_restart_count", wr_count, 32'd0);
    run_to_done(1'b0, -1, 20);
    checkOutput("t6_wr_count", wr_count, 32'd4);
    checkOutput("t6_writes", 32'(writes_seen), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
